control_sequencer: RTL

- Parametrised microcoded control unit for the 8-bit bus computer; successor to the fixed SAP-style control logic.
- Holds the T-state step counter, the carry/zero flag register and the halt latch.
- Decodes the instruction register and flags into the bus control word: MI, RI, RO, II, IO, AI, AO, BI, EO, SU, OI, CE, CO, J, FI, HLT.
- Adds three things the fixed control logic lacks: conditional jumps (JC/JZ), early exit of empty T-states, and a single-step enable.

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus computer: T-state counter, flags, halt latch
// and the combinational control-word decode with conditional jumps and early exit.
//
// T-state | meaning
// T0      | fetch: program counter onto bus, load memory address
// T1      | fetch: memory onto bus into instruction register, bump PC
// T2..T4  | execute micro-steps per opcode
// T5..    | always empty (only reached when EARLY_EXIT=0 or opcode fills them)
module control_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_COUNT = 5,
    parameter int STEP_WIDTH = 3,
    parameter int EARLY_EXIT = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    output logic                  MI,
    output logic                  RI,
    output logic                  RO,
    output logic                  II,
    output logic                  IO,
    output logic                  AI,
    output logic                  AO,
    output logic                  BI,
    output logic                  EO,
    output logic                  SU,
    output logic                  OI,
    output logic                  CE,
    output logic                  CO,
    output logic                  J,
    output logic                  FI,
    output logic                  HLT,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  carry_flag,
    output logic                  zero_flag
);

    localparam logic [STEP_WIDTH-1:0] T0 = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] T1 = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] T2 = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] T3 = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] T4 = STEP_WIDTH'(4);
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEP_COUNT - 1);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [15:0] CW_MI  = 16'h0001;
    localparam logic [15:0] CW_RI  = 16'h0002;
    localparam logic [15:0] CW_RO  = 16'h0004;
    localparam logic [15:0] CW_II  = 16'h0008;
    localparam logic [15:0] CW_IO  = 16'h0010;
    localparam logic [15:0] CW_AI  = 16'h0020;
    localparam logic [15:0] CW_AO  = 16'h0040;
    localparam logic [15:0] CW_BI  = 16'h0080;
    localparam logic [15:0] CW_EO  = 16'h0100;
    localparam logic [15:0] CW_SU  = 16'h0200;
    localparam logic [15:0] CW_OI  = 16'h0400;
    localparam logic [15:0] CW_CE  = 16'h0800;
    localparam logic [15:0] CW_CO  = 16'h1000;
    localparam logic [15:0] CW_J   = 16'h2000;
    localparam logic [15:0] CW_FI  = 16'h4000;
    localparam logic [15:0] CW_HLT = 16'h8000;

    logic [3:0]            opcode;
    logic                  halt_latch;
    logic [15:0]           word_raw;
    logic [15:0]           ctrl_word;
    logic [STEP_WIDTH-1:0] step_next;
    logic [STEP_WIDTH-1:0] step_inc;
    logic                  advance;
    logic                  unused_instr_bits;

    assign opcode            = instr[DATA_WIDTH-1 -: 4];
    assign unused_instr_bits = ^instr[DATA_WIDTH-5:0];

    function automatic logic [15:0] decode(
        input logic [STEP_WIDTH-1:0] t,
        input logic [3:0]            op,
        input logic                  cf,
        input logic                  zf
    );
        logic [15:0] w;
        w = '0;
        if (t == T0) begin
            w = CW_CO | CW_MI;
        end else if (t == T1) begin
            w = CW_RO | CW_II | CW_CE;
        end else if (t == T2) begin
            case (op)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: w = CW_IO | CW_MI;
                OP_LDI: w = CW_IO | CW_AI;
                OP_JMP: w = CW_IO | CW_J;
                OP_JC:  w = cf ? (CW_IO | CW_J) : '0;
                OP_JZ:  w = zf ? (CW_IO | CW_J) : '0;
                OP_OUT: w = CW_AO | CW_OI;
                OP_HLT: w = CW_HLT;
                default: w = '0;
            endcase
        end else if (t == T3) begin
            case (op)
                OP_LDA:         w = CW_RO | CW_AI;
                OP_ADD, OP_SUB: w = CW_RO | CW_BI;
                OP_STA:         w = CW_AO | CW_RI;
                default:        w = '0;
            endcase
        end else if (t == T4) begin
            case (op)
                OP_ADD:  w = CW_EO | CW_AI | CW_FI;
                OP_SUB:  w = CW_EO | CW_AI | CW_FI | CW_SU;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    assign word_raw = decode(step, opcode, carry_flag, zero_flag);

    // Reset forces the word to zero without waiting for the clock; halt masks all but HLT.
    always_comb begin
        ctrl_word = word_raw;
        if (!reset_n) begin
            ctrl_word = '0;
        end else if (halt_latch) begin
            ctrl_word = CW_HLT;
        end
    end

    assign MI  = ctrl_word[0];
    assign RI  = ctrl_word[1];
    assign RO  = ctrl_word[2];
    assign II  = ctrl_word[3];
    assign IO  = ctrl_word[4];
    assign AI  = ctrl_word[5];
    assign AO  = ctrl_word[6];
    assign BI  = ctrl_word[7];
    assign EO  = ctrl_word[8];
    assign SU  = ctrl_word[9];
    assign OI  = ctrl_word[10];
    assign CE  = ctrl_word[11];
    assign CO  = ctrl_word[12];
    assign J   = ctrl_word[13];
    assign FI  = ctrl_word[14];
    assign HLT = ctrl_word[15];

    // The step that decodes HLT must not move, so the halted machine parks on T2.
    assign advance  = enable && !halt_latch && !word_raw[15];
    assign step_inc = step + STEP_WIDTH'(1);

    always_comb begin
        step_next = step_inc;
        if (step == LAST_STEP) begin
            step_next = T0;
        end else if ((EARLY_EXIT != 0) && (step != T0) &&
                     (decode(step_inc, opcode, carry_flag, zero_flag) == 16'h0000)) begin
            step_next = T0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step       <= T0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            halt_latch <= 1'b0;
        end else if (enable) begin
            if (advance) begin
                step <= step_next;
            end
            if (word_raw[14] && !halt_latch) begin
                carry_flag <= alu_carry;
                zero_flag  <= alu_zero;
            end
            if (word_raw[15]) begin
                halt_latch <= 1'b1;
            end
        end
    end

endmodule
